// File: rtl/axi_pkg.sv
// -----------------------------------------------------------------------------
// axi_pkg
// Shared definitions for the AXI interconnect arbiters and decoders:
//   - slave address windows (base/limit) for S1..S5
//   - zero-based slave index encoding produced by the address decoder
//   - routing codes handed to the response muxes (ROUTE_IDLE, ROUTE_S1..S5)
//   - write-address arbiter state enum
//   - AXI response codes
// -----------------------------------------------------------------------------
package axi_pkg;

    localparam int NUM_SLAVES = 5;

    localparam logic [31:0] S1_BASE  = 32'h0000_0000;
    localparam logic [31:0] S1_LIMIT = 32'h0000_3FFF;
    localparam logic [31:0] S2_BASE  = 32'h0001_0000;
    localparam logic [31:0] S2_LIMIT = 32'h0001_FFFF;
    localparam logic [31:0] S3_BASE  = 32'h0002_0000;
    localparam logic [31:0] S3_LIMIT = 32'h0002_FFFF;
    localparam logic [31:0] S4_BASE  = 32'h1000_0000;
    localparam logic [31:0] S4_LIMIT = 32'h1000_03FF;
    localparam logic [31:0] S5_BASE  = 32'h2000_0000;
    localparam logic [31:0] S5_LIMIT = 32'h201F_FFFF;

    // Zero-based slave index; also the bit position in the one-hot slave vectors.
    typedef enum logic [2:0] {
        SLV_S1 = 3'd0,
        SLV_S2 = 3'd1,
        SLV_S3 = 3'd2,
        SLV_S4 = 3'd3,
        SLV_S5 = 3'd4
    } slv_idx_e;

    // Routing code = {one-based slave number + 1, 1'b1}; all-zero means no route.
    localparam logic [3:0] ROUTE_IDLE = 4'b0000;
    localparam logic [3:0] ROUTE_S1   = 4'b0101;
    localparam logic [3:0] ROUTE_S2   = 4'b0111;
    localparam logic [3:0] ROUTE_S3   = 4'b1001;
    localparam logic [3:0] ROUTE_S4   = 4'b1011;
    localparam logic [3:0] ROUTE_S5   = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } arb_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic logic [3:0] route_code(input logic [2:0] idx);
        logic [3:0] code;
        case (idx)
            SLV_S1:  code = ROUTE_S1;
            SLV_S2:  code = ROUTE_S2;
            SLV_S3:  code = ROUTE_S3;
            SLV_S4:  code = ROUTE_S4;
            default: code = ROUTE_S5;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/axi_addr_decoder.sv
// -----------------------------------------------------------------------------
// axi_addr_decoder
// Pure combinational address-to-slave decode, shared by the read and write
// arbiters. Anything outside the S1..S4 windows lands on S5, which doubles as
// the default slave.
// Ports:
//   addr    in  ADDR_W  transaction address
//   slv_idx out 3       zero-based slave index (slv_idx_e encoding)
// -----------------------------------------------------------------------------
module axi_addr_decoder
    import axi_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [2:0]        slv_idx
);

    function automatic logic in_range(input logic [ADDR_W-1:0] a,
                                      input logic [ADDR_W-1:0] base,
                                      input logic [ADDR_W-1:0] limit);
        return (a >= base) && (a <= limit);
    endfunction

    always_comb begin
        slv_idx = SLV_S5;
        if (in_range(addr, ADDR_W'(S1_BASE), ADDR_W'(S1_LIMIT))) begin
            slv_idx = SLV_S1;
        end else if (in_range(addr, ADDR_W'(S2_BASE), ADDR_W'(S2_LIMIT))) begin
            slv_idx = SLV_S2;
        end else if (in_range(addr, ADDR_W'(S3_BASE), ADDR_W'(S3_LIMIT))) begin
            slv_idx = SLV_S3;
        end else if (in_range(addr, ADDR_W'(S4_BASE), ADDR_W'(S4_LIMIT))) begin
            slv_idx = SLV_S4;
        end
    end

endmodule

// File: rtl/write_addr_arb.sv
// -----------------------------------------------------------------------------
// write_addr_arb
// Write-address arbiter/decoder for master M1. Takes one AW at a time, decodes
// it to S1..S5, forwards the latched AW to that slave, steers the W burst to it
// and holds the route (AW_arbiter) until the B handshake completes on M1.
// Ports:
//   ACLK, ARESET                 clock, synchronous active-high reset
//   AW*_M1 / AWREADY_M1          master write-address channel
//   W*_M1  / WREADY_M1           master write-data channel
//   AW*_S, AWVALID_S/AWREADY_S   broadcast AW payload, one-hot valid per slave
//   W*_S,  WVALID_S/WREADY_S     broadcast W payload, one-hot valid per slave
//   BVALID_M1, BREADY_M1         B handshake seen at M1 side of the response mux
//   AW_arbiter                   routing code for the write-response mux
//   PROT_ERR                     sticky WLAST/AWLEN mismatch flag
// -----------------------------------------------------------------------------
module write_addr_arb
    import axi_pkg::*;
#(
    parameter int         ADDR_W     = 32,
    parameter int         DATA_W     = 32,
    parameter int         ID_W       = 4,
    parameter int         IDS_W      = 8,
    parameter int         LEN_W      = 4,
    parameter logic [3:0] MASTER_TAG = 4'b0001
) (
    input  logic                  ACLK,
    input  logic                  ARESET,

    input  logic [ID_W-1:0]       AWID_M1,
    input  logic [ADDR_W-1:0]     AWADDR_M1,
    input  logic [LEN_W-1:0]      AWLEN_M1,
    input  logic [2:0]            AWSIZE_M1,
    input  logic [1:0]            AWBURST_M1,
    input  logic                  AWVALID_M1,
    output logic                  AWREADY_M1,

    input  logic [DATA_W-1:0]     WDATA_M1,
    input  logic [DATA_W/8-1:0]   WSTRB_M1,
    input  logic                  WLAST_M1,
    input  logic                  WVALID_M1,
    output logic                  WREADY_M1,

    output logic [IDS_W-1:0]      AWID_S,
    output logic [ADDR_W-1:0]     AWADDR_S,
    output logic [LEN_W-1:0]      AWLEN_S,
    output logic [2:0]            AWSIZE_S,
    output logic [1:0]            AWBURST_S,
    output logic [4:0]            AWVALID_S,
    input  logic [4:0]            AWREADY_S,

    output logic [DATA_W-1:0]     WDATA_S,
    output logic [DATA_W/8-1:0]   WSTRB_S,
    output logic                  WLAST_S,
    output logic [4:0]            WVALID_S,
    input  logic [4:0]            WREADY_S,

    input  logic                  BVALID_M1,
    input  logic                  BREADY_M1,

    output logic [3:0]            AW_arbiter,
    output logic                  PROT_ERR
);

    arb_state_e        state_q, state_d;
    logic [2:0]        dec_idx;
    logic [2:0]        sel_q;
    logic [4:0]        sel_oh;
    logic [3:0]        route_q;
    logic [IDS_W-1:0]  awid_q;
    logic [ADDR_W-1:0] awaddr_q;
    logic [LEN_W-1:0]  awlen_q;
    logic [2:0]        awsize_q;
    logic [1:0]        awburst_q;
    logic [LEN_W-1:0]  beat_cnt_q;
    logic              prot_err_q;
    logic              aw_hs, w_hs, b_hs, last_beat;

    axi_addr_decoder #(.ADDR_W(ADDR_W)) u_addr_decoder (
        .addr    (AWADDR_M1),
        .slv_idx (dec_idx)
    );

    assign sel_oh    = 5'(1) << sel_q;
    assign aw_hs     = (state_q == ST_IDLE) && AWVALID_M1;
    assign w_hs      = (state_q == ST_DATA) && WVALID_M1 && WREADY_S[sel_q];
    assign b_hs      = (state_q == ST_RESP) && BVALID_M1 && BREADY_M1;
    assign last_beat = (beat_cnt_q == awlen_q);

    // AW payload is the registered copy so it stays stable while the slave stalls.
    assign AWID_S     = awid_q;
    assign AWADDR_S   = awaddr_q;
    assign AWLEN_S    = awlen_q;
    assign AWSIZE_S   = awsize_q;
    assign AWBURST_S  = awburst_q;

    // W payload is broadcast combinationally; only the one-hot valid selects a slave.
    assign WDATA_S    = WDATA_M1;
    assign WSTRB_S    = WSTRB_M1;
    assign WLAST_S    = WLAST_M1;

    assign AW_arbiter = route_q;
    assign PROT_ERR   = prot_err_q;

    always_comb begin
        state_d    = state_q;
        AWREADY_M1 = 1'b0;
        AWVALID_S  = 5'b00000;
        WVALID_S   = 5'b00000;
        WREADY_M1  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                AWREADY_M1 = 1'b1;
                if (AWVALID_M1) begin
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                AWVALID_S = sel_oh;
                if (AWREADY_S[sel_q]) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                WVALID_S  = WVALID_M1 ? sel_oh : 5'b00000;
                WREADY_M1 = WREADY_S[sel_q];
                if (w_hs && last_beat) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (b_hs) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= ST_IDLE;
            sel_q      <= 3'd0;
            route_q    <= ROUTE_IDLE;
            awid_q     <= '0;
            awaddr_q   <= '0;
            awlen_q    <= '0;
            awsize_q   <= '0;
            awburst_q  <= '0;
            beat_cnt_q <= '0;
            prot_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (aw_hs) begin
                sel_q      <= dec_idx;
                route_q    <= route_code(dec_idx);
                awid_q     <= IDS_W'({MASTER_TAG, AWID_M1});
                awaddr_q   <= AWADDR_M1;
                awlen_q    <= AWLEN_M1;
                awsize_q   <= AWSIZE_M1;
                awburst_q  <= AWBURST_M1;
                beat_cnt_q <= '0;
            end
            if (w_hs) begin
                // Holding the count on the final beat keeps a 16-beat burst from wrapping.
                if (!last_beat) begin
                    beat_cnt_q <= beat_cnt_q + LEN_W'(1);
                end
                if (WLAST_M1 != last_beat) begin
                    prot_err_q <= 1'b1;
                end
            end
            if (b_hs) begin
                route_q <= ROUTE_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_write_addr_arb.sv
module tb_write_addr_arb;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [3:0]  AWID_M1;
    logic [31:0] AWADDR_M1;
    logic [3:0]  AWLEN_M1;
    logic [2:0]  AWSIZE_M1;
    logic [1:0]  AWBURST_M1;
    logic        AWVALID_M1;
    logic        AWREADY_M1;
    logic [31:0] WDATA_M1;
    logic [3:0]  WSTRB_M1;
    logic        WLAST_M1;
    logic        WVALID_M1;
    logic        WREADY_M1;
    logic [7:0]  AWID_S;
    logic [31:0] AWADDR_S;
    logic [3:0]  AWLEN_S;
    logic [2:0]  AWSIZE_S;
    logic [1:0]  AWBURST_S;
    logic [4:0]  AWVALID_S;
    logic [4:0]  AWREADY_S;
    logic [31:0] WDATA_S;
    logic [3:0]  WSTRB_S;
    logic        WLAST_S;
    logic [4:0]  WVALID_S;
    logic [4:0]  WREADY_S;
    logic        BVALID_M1;
    logic        BREADY_M1;
    logic [3:0]  AW_arbiter;
    logic        PROT_ERR;

    write_addr_arb dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWID_M1(AWID_M1), .AWADDR_M1(AWADDR_M1), .AWLEN_M1(AWLEN_M1),
        .AWSIZE_M1(AWSIZE_M1), .AWBURST_M1(AWBURST_M1),
        .AWVALID_M1(AWVALID_M1), .AWREADY_M1(AWREADY_M1),
        .WDATA_M1(WDATA_M1), .WSTRB_M1(WSTRB_M1), .WLAST_M1(WLAST_M1),
        .WVALID_M1(WVALID_M1), .WREADY_M1(WREADY_M1),
        .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S),
        .AWSIZE_S(AWSIZE_S), .AWBURST_S(AWBURST_S),
        .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
        .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S),
        .WVALID_S(WVALID_S), .WREADY_S(WREADY_S),
        .BVALID_M1(BVALID_M1), .BREADY_M1(BREADY_M1),
        .AW_arbiter(AW_arbiter), .PROT_ERR(PROT_ERR)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;
    bit exp_prot = 1'b0;

    typedef struct {
        logic [4:0]  oh;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [7:0]  id;
        logic [3:0]  route;
    } aw_exp_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
        logic [4:0]  oh;
        logic [3:0]  route;
    } w_exp_t;

    aw_exp_t aw_q[$];
    w_exp_t  w_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic abort_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL timeout %s: no handshake within cycle budget at %0t", name, $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    task automatic next_cycle();
        @(posedge ACLK);
        #1;
    endtask

    // Reference address map: slave number 1..5, unmapped goes to 5.
    function automatic int model_slave(input logic [31:0] a);
        if (a <= 32'h0000_3FFF) return 1;
        if (a >= 32'h0001_0000 && a <= 32'h0001_FFFF) return 2;
        if (a >= 32'h0002_0000 && a <= 32'h0002_FFFF) return 3;
        if (a >= 32'h1000_0000 && a <= 32'h1000_03FF) return 4;
        return 5;
    endfunction

    function automatic logic [3:0] model_route(input int s);
        return 4'((s + 1) * 2 + 1);
    endfunction

    function automatic logic [4:0] model_oh(input int s);
        return 5'(1 << (s - 1));
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] edges [8];
        edges = '{32'h0000_4000, 32'h0000_FFFF, 32'h0003_0000, 32'h1000_0400,
                  32'h0FFF_FFFF, 32'h2020_0000, 32'hFFFF_FFFF, 32'h0000_3FFF};
        case ($urandom_range(0, 6))
            0: return 32'($urandom_range(0, 32'h3FFF));
            1: return 32'h0001_0000 + 32'($urandom_range(0, 32'hFFFF));
            2: return 32'h0002_0000 + 32'($urandom_range(0, 32'hFFFF));
            3: return 32'h1000_0000 + 32'($urandom_range(0, 32'h3FF));
            4: return 32'h2000_0000 + 32'($urandom_range(0, 32'h1F_FFFF));
            5: return edges[$urandom_range(0, 7)];
            default: return 32'($urandom);
        endcase
    endfunction

    // Slave-side monitor: every forwarded AW/W handshake must match the next expected item.
    always @(negedge ACLK) begin
        aw_exp_t ae;
        w_exp_t  we;
        if (!ARESET) begin
            if ((AWVALID_S & AWREADY_S) != 5'b0) begin
                if (aw_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL aw_unexpected: got AWVALID_S 0x%0h expected no AW", AWVALID_S);
                end else begin
                    ae = aw_q.pop_front();
                    chk("aw_valid_oh", 64'(AWVALID_S), 64'(ae.oh));
                    chk("aw_addr", 64'(AWADDR_S), 64'(ae.addr));
                    chk("aw_len", 64'(AWLEN_S), 64'(ae.len));
                    chk("aw_size", 64'(AWSIZE_S), 64'(ae.size));
                    chk("aw_burst", 64'(AWBURST_S), 64'(ae.burst));
                    chk("aw_id", 64'(AWID_S), 64'(ae.id));
                    chk("aw_route", 64'(AW_arbiter), 64'(ae.route));
                end
            end
            if ((WVALID_S & WREADY_S) != 5'b0) begin
                if (w_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL w_unexpected: got WVALID_S 0x%0h expected no beat", WVALID_S);
                end else begin
                    we = w_q.pop_front();
                    chk("w_valid_oh", 64'(WVALID_S), 64'(we.oh));
                    chk("w_data", 64'(WDATA_S), 64'(we.data));
                    chk("w_strb", 64'(WSTRB_S), 64'(we.strb));
                    chk("w_last", 64'(WLAST_S), 64'(we.last));
                    chk("w_ready_m1", 64'(WREADY_M1), 64'(1));
                    chk("w_route", 64'(AW_arbiter), 64'(we.route));
                end
            end
        end
    end

    // wmode: 0 = slave always ready, 1 = slave ready every other cycle, 2 = random both sides.
    // bad: beat index whose WLAST is inverted, or -1 for a well-formed burst.
    task automatic run_txn(input logic [31:0] addr, input int len, input int aw_delay,
                           input int wmode, input int bad);
        int          s;
        logic [4:0]  oh;
        logic [3:0]  rt;
        logic [31:0] dat [16];
        logic [3:0]  stb [16];
        logic        lst [16];
        aw_exp_t     ae;
        w_exp_t      we;
        int          i;
        int          budget;
        bit          hs;
        bit          wv;
        logic [4:0]  wr;

        s  = model_slave(addr);
        oh = model_oh(s);
        rt = model_route(s);

        AWADDR_M1  = addr;
        AWLEN_M1   = 4'(len);
        AWID_M1    = 4'($urandom);
        AWSIZE_M1  = 3'($urandom);
        AWBURST_M1 = 2'($urandom);
        AWVALID_M1 = 1'b1;
        ae = '{oh: oh, addr: addr, len: 4'(len), size: AWSIZE_M1, burst: AWBURST_M1,
               id: {4'b0001, AWID_M1}, route: rt};
        aw_q.push_back(ae);
        for (int k = 0; k <= len; k++) begin
            dat[k] = 32'($urandom);
            stb[k] = 4'($urandom);
            lst[k] = (k == len) ^ (k == bad);
            we = '{data: dat[k], strb: stb[k], last: lst[k], oh: oh, route: rt};
            w_q.push_back(we);
        end
        #1;
        chk("idle_awready", 64'(AWREADY_M1), 64'(1));
        chk("idle_route", 64'(AW_arbiter), 64'(0));

        // Address phase: master side released, W beat offered early must stall.
        next_cycle();
        AWVALID_M1 = 1'b0;
        AWADDR_M1  = 32'($urandom);
        AWLEN_M1   = 4'($urandom);
        AWREADY_S  = 5'b0;
        WVALID_M1  = 1'b1;
        WDATA_M1   = dat[0];
        WSTRB_M1   = stb[0];
        WLAST_M1   = lst[0];
        #1;
        chk("addr_awvalid_s", 64'(AWVALID_S), 64'(oh));
        chk("addr_route", 64'(AW_arbiter), 64'(rt));
        chk("addr_awready_m1", 64'(AWREADY_M1), 64'(0));
        for (int d = 0; d < aw_delay; d++) begin
            next_cycle();
            #1;
            chk("stall_awvalid_s", 64'(AWVALID_S), 64'(oh));
            chk("stall_awaddr_s", 64'(AWADDR_S), 64'(addr));
            chk("stall_wready_m1", 64'(WREADY_M1), 64'(0));
            chk("stall_wvalid_s", 64'(WVALID_S), 64'(0));
        end
        AWREADY_S = 5'($urandom) | oh;
        next_cycle();
        AWREADY_S = 5'b0;

        // Data phase.
        i = 0;
        budget = 0;
        while (i <= len) begin
            wv = (wmode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            wr = 5'($urandom);
            if (wmode == 0) wr = wr | oh;
            if (wmode == 1) wr = (budget % 2 == 0) ? (wr | oh) : (wr & ~oh);
            WVALID_M1 = wv;
            WDATA_M1  = dat[i];
            WSTRB_M1  = stb[i];
            WLAST_M1  = lst[i];
            WREADY_S  = wr;
            hs = wv && ((wr & oh) != 5'b0);
            next_cycle();
            if (hs) i++;
            budget++;
            if (budget > 200) abort_timeout("w_burst");
        end

        // Response phase: no further beats may be taken.
        WVALID_M1 = 1'b1;
        WDATA_M1  = 32'($urandom);
        WLAST_M1  = 1'b0;
        WREADY_S  = 5'b11111;
        #1;
        chk("resp_wready_m1", 64'(WREADY_M1), 64'(0));
        chk("resp_wvalid_s", 64'(WVALID_S), 64'(0));
        chk("beats_left", 64'(w_q.size()), 64'(0));
        chk("aw_left", 64'(aw_q.size()), 64'(0));
        if (bad >= 0) exp_prot = 1'b1;
        chk("prot_err", 64'(PROT_ERR), 64'(exp_prot));
        WVALID_M1 = 1'b0;
        WREADY_S  = 5'b0;
        budget = 0;
        do begin
            BVALID_M1 = 1'($urandom_range(0, 1));
            BREADY_M1 = 1'($urandom_range(0, 1));
            hs = BVALID_M1 && BREADY_M1;
            #1;
            chk("resp_route", 64'(AW_arbiter), 64'(rt));
            next_cycle();
            budget++;
        end while (!hs && budget < 50);
        if (!hs) abort_timeout("b_handshake");
        BVALID_M1 = 1'b0;
        BREADY_M1 = 1'b0;
        #1;
        chk("post_b_route", 64'(AW_arbiter), 64'(0));
        chk("post_b_awready", 64'(AWREADY_M1), 64'(1));
    endtask

    task automatic reset_mid_data();
        aw_exp_t ae;
        w_exp_t  we;
        AWADDR_M1  = 32'h1000_0100;
        AWLEN_M1   = 4'd7;
        AWID_M1    = 4'hA;
        AWSIZE_M1  = 3'd2;
        AWBURST_M1 = 2'd1;
        AWVALID_M1 = 1'b1;
        ae = '{oh: 5'b01000, addr: 32'h1000_0100, len: 4'd7, size: 3'd2, burst: 2'd1,
               id: 8'h1A, route: 4'b1011};
        aw_q.push_back(ae);
        next_cycle();
        AWVALID_M1 = 1'b0;
        AWREADY_S  = 5'b01000;
        next_cycle();
        AWREADY_S = 5'b0;
        WVALID_M1 = 1'b1;
        WDATA_M1  = 32'hCAFE_0001;
        WSTRB_M1  = 4'hF;
        WLAST_M1  = 1'b0;
        WREADY_S  = 5'b01000;
        we = '{data: 32'hCAFE_0001, strb: 4'hF, last: 1'b0, oh: 5'b01000, route: 4'b1011};
        w_q.push_back(we);
        next_cycle();
        WVALID_M1 = 1'b0;
        WREADY_S  = 5'b0;
        ARESET    = 1'b1;
        #1;
        chk("pre_reset_route", 64'(AW_arbiter), 64'(4'b1011));
        next_cycle();
        ARESET    = 1'b0;
        WVALID_M1 = 1'b1;
        WREADY_S  = 5'b11111;
        exp_prot  = 1'b0;
        #1;
        chk("rst_route", 64'(AW_arbiter), 64'(0));
        chk("rst_awvalid_s", 64'(AWVALID_S), 64'(0));
        chk("rst_wvalid_s", 64'(WVALID_S), 64'(0));
        chk("rst_wready_m1", 64'(WREADY_M1), 64'(0));
        chk("rst_awready_m1", 64'(AWREADY_M1), 64'(1));
        chk("rst_prot_err", 64'(PROT_ERR), 64'(0));
        chk("rst_awaddr_s", 64'(AWADDR_S), 64'(0));
        chk("rst_queues", 64'(aw_q.size() + w_q.size()), 64'(0));
        WVALID_M1 = 1'b0;
        WREADY_S  = 5'b0;
    endtask

    initial begin
        ARESET     = 1'b1;
        AWID_M1    = '0;
        AWADDR_M1  = '0;
        AWLEN_M1   = '0;
        AWSIZE_M1  = '0;
        AWBURST_M1 = '0;
        AWVALID_M1 = 1'b0;
        WDATA_M1   = '0;
        WSTRB_M1   = '0;
        WLAST_M1   = 1'b0;
        WVALID_M1  = 1'b0;
        AWREADY_S  = '0;
        WREADY_S   = '0;
        BVALID_M1  = 1'b0;
        BREADY_M1  = 1'b0;
        repeat (3) next_cycle();
        ARESET = 1'b0;
        #1;
        chk("reset_awready_m1", 64'(AWREADY_M1), 64'(1));
        chk("reset_route", 64'(AW_arbiter), 64'(0));
        chk("reset_awvalid_s", 64'(AWVALID_S), 64'(0));
        chk("reset_wvalid_s", 64'(WVALID_S), 64'(0));
        chk("reset_wready_m1", 64'(WREADY_M1), 64'(0));
        chk("reset_prot_err", 64'(PROT_ERR), 64'(0));
        chk("reset_awaddr_s", 64'(AWADDR_S), 64'(0));
        chk("reset_awid_s", 64'(AWID_S), 64'(0));

        run_txn(32'h0002_0010, 0, 0, 0, -1);   // S3 single beat
        run_txn(32'h0000_0100, 3, 0, 1, -1);   // S1 burst, toggling ready
        run_txn(32'h3000_0000, 0, 0, 0, -1);   // unmapped -> S5
        run_txn(32'h0001_0040, 2, 6, 0, -1);   // long AW stall
        run_txn(32'h2000_1000, 1, 0, 0, 0);    // early WLAST -> sticky PROT_ERR
        run_txn(32'h0000_0000, 15, 1, 2, -1);  // max length burst

        for (int n = 0; n < 25; n++) begin
            int len;
            int bad;
            len = $urandom_range(0, 15);
            bad = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len) : -1;
            run_txn(rand_addr(), len, $urandom_range(0, 3), $urandom_range(0, 2), bad);
        end

        reset_mid_data();

        for (int n = 0; n < 5; n++) begin
            run_txn(rand_addr(), $urandom_range(0, 15), $urandom_range(0, 2),
                    $urandom_range(0, 2), -1);
        end

        repeat (2) next_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        checks++;
        errors++;
        $display("FAIL global_timeout: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
